gcd_arbiter: RTL and testbench

GCD_ARBITER -- requirements
Module: gcd_arbiter

---
 rtl/gcd_arbiter.sv | 89 ++++++++
 tb/tb_gcd_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin arbiter that shares one GCD core among four requesters.
module gcd_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic [3:0]         grant,
  output logic [3:0]         done,
  output logic [WIDTH-1:0]   result,
  output logic               err,
  output logic               busy,
  output logic               core_rst,
  output logic [WIDTH-1:0]   core_a,
  output logic [WIDTH-1:0]   core_b,
  output logic               core_a_available,
  output logic               core_b_available,
  input  logic [WIDTH-1:0]   core_out,
  input  logic               core_out_ready
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_A, LOAD_B, WAIT, DONE} state_t;
  state_t state, state_d;
  logic [1:0] ptr, sel;
  logic [WIDTH-1:0] a_q, b_q, cand_a, cand_b;
  logic [CW-1:0] wait_cnt;
  logic err_q, rst_hold, timed_out;
  // Scan downwards so the requester closest to ptr wins.
  always_comb begin
    sel = ptr;
    for (int k = 3; k >= 0; k--) if (req[ptr + 2'(k)]) sel = ptr + 2'(k);
  end
  assign cand_a = req_a[sel*WIDTH +: WIDTH];
  assign cand_b = req_b[sel*WIDTH +: WIDTH];
  assign timed_out = wait_cnt == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = ~|req ? IDLE : (cand_a == '0 || cand_b == '0) ? DONE : CLEAR;
      CLEAR:   state_d = LOAD_A;
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = WAIT;
      WAIT:    state_d = (core_out_ready || timed_out) ? DONE : WAIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign busy             = state != IDLE;
  assign done             = state == DONE ? grant : '0;
  assign err              = state == DONE && err_q;
  assign core_rst         = rst_hold || state == CLEAR;
  assign core_a_available = state inside {LOAD_A, LOAD_B, WAIT};
  assign core_b_available = state == LOAD_B;
  assign core_a           = a_q;
  assign core_b           = b_q;
  // rst_hold keeps the core in restart until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result   <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
      rst_hold <= 1'b1;
    end else begin
      state    <= state_d;
      rst_hold <= 1'b0;
      if (state == IDLE && |req) begin
        grant  <= 4'b1 << sel;
        ptr    <= sel + 2'd1;
        a_q    <= cand_a < cand_b ? cand_b : cand_a;
        b_q    <= cand_a < cand_b ? cand_a : cand_b;
        err_q  <= cand_a == '0 || cand_b == '0;
        result <= '0;
      end
      if (state == LOAD_B) wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);
      if (state == WAIT && core_out_ready) result <= core_out;
      if (state == WAIT && !core_out_ready && timed_out) err_q <= 1'b1;
      if (state == DONE) grant <= '0;
    end
  end
endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: randomized bench with a behavioural GCD core and round-robin model.
module tb_gcd_arbiter;
  localparam int W  = 8;
  localparam int TO = 20;
  logic clk = 0, rst = 1;
  logic [3:0] req = '0;
  logic [4*W-1:0] req_a = '0, req_b = '0;
  logic [3:0] grant, done;
  logic [W-1:0] result, core_a, core_b;
  logic err, busy, core_rst, core_a_available, core_b_available;
  logic [W-1:0] core_out = '0;
  logic core_out_ready = 1'b0;
  int checks = 0, errors = 0;
  int fixed_dly = -1, rr_ptr = 0, dly = 0;
  bit never_ready = 0, pend = 0;
  logic [W-1:0] ca, cb;

  gcd_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .grant(grant), .done(done), .result(result), .err(err), .busy(busy),
    .core_rst(core_rst), .core_a(core_a), .core_b(core_b),
    .core_a_available(core_a_available), .core_b_available(core_b_available),
    .core_out(core_out), .core_out_ready(core_out_ready)
  );

  always #5 clk = ~clk;

  function automatic int gcd_ref(int a, int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int pick(int p, logic [3:0] r);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Behavioural core: latches operands on the b strobe, answers after a delay.
  always @(posedge clk) begin
    core_out_ready <= 1'b0;
    if (core_rst) pend <= 0;
    else if (core_b_available) begin
      int d;
      d = fixed_dly >= 0 ? fixed_dly : int'($urandom_range(0, 3));
      if (never_ready) pend <= 0;
      else if (d == 0) begin
        core_out_ready <= 1'b1;
        core_out <= W'(gcd_ref(int'(core_a), int'(core_b)));
        pend <= 0;
      end else begin
        pend <= 1;
        dly <= d - 1;
        ca <= core_a;
        cb <= core_b;
      end
    end else if (pend) begin
      if (dly == 0) begin
        core_out_ready <= 1'b1;
        core_out <= W'(gcd_ref(int'(ca), int'(cb)));
        pend <= 0;
      end else dly <= dly - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic check_op(input int idx, input bit drop, input bit exp_to, input bit chk_lat);
    int n, ea, eb, exp_res;
    bit zero, exp_err;
    ea = int'(req_a[idx*W +: W]);
    eb = int'(req_b[idx*W +: W]);
    n = 0;
    while (grant == 4'b0 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (grant !== 4'(1 << idx)) begin
      errors++;
      $display("FAIL grant: got %b expected %b", grant, 4'(1 << idx));
    end
    rr_ptr = (idx + 1) % 4;
    if (drop) req[idx] = 1'b0;
    zero = ea == 0 || eb == 0;
    exp_err = zero || exp_to;
    exp_res = exp_err ? 0 : gcd_ref(ea, eb);
    if (zero) begin
      checks++;
      if ({core_rst, core_a_available, core_b_available} !== 3'b000) begin
        errors++;
        $display("FAIL zero_strobes: got %b expected 000", {core_rst, core_a_available, core_b_available});
      end
    end else begin
      checks++;
      if ({core_rst, core_a_available, core_b_available} !== 3'b100) begin
        errors++;
        $display("FAIL clear: got %b expected 100", {core_rst, core_a_available, core_b_available});
      end
      tick();
      checks++;
      if ({core_rst, core_a_available, core_b_available} !== 3'b010 || core_a !== W'(ea >= eb ? ea : eb)) begin
        errors++;
        $display("FAIL load_a: strobes %b core_a %0d expected 010 %0d", {core_rst, core_a_available, core_b_available}, core_a, ea >= eb ? ea : eb);
      end
      tick();
      checks++;
      if ({core_rst, core_a_available, core_b_available} !== 3'b011 || core_b !== W'(ea >= eb ? eb : ea)) begin
        errors++;
        $display("FAIL load_b: strobes %b core_b %0d expected 011 %0d", {core_rst, core_a_available, core_b_available}, core_b, ea >= eb ? eb : ea);
      end
      tick();
      n = 3;
      while (done == 4'b0 && n < TO + 10) begin
        tick();
        n++;
      end
      if (exp_to || chk_lat) begin
        checks++;
        if (n != (exp_to ? TO + 3 : 4)) begin
          errors++;
          $display("FAIL latency: got %0d expected %0d", n, exp_to ? TO + 3 : 4);
        end
      end
    end
    checks++;
    if (done !== 4'(1 << idx) || result !== W'(exp_res) || err !== exp_err) begin
      errors++;
      $display("FAIL done: done %b result %0d err %b expected %b %0d %b", done, result, err, 4'(1 << idx), exp_res, exp_err);
    end
    tick();
    checks++;
    if (done !== 4'b0 || grant !== 4'b0) begin
      errors++;
      $display("FAIL after_done: done %b grant %b expected 0000 0000", done, grant);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (grant !== 4'b0 || done !== 4'b0 || result !== '0 || err !== 1'b0 || busy !== 1'b0 ||
        core_rst !== 1'b1 || core_a_available !== 1'b0 || core_b_available !== 1'b0) begin
      errors++;
      $display("FAIL %s: grant %b done %b result %0d err %b busy %b core_rst %b av %b%b expected reset values",
               tag, grant, done, result, err, busy, core_rst, core_a_available, core_b_available);
    end
  endtask

  task automatic test_reset();
    #2 rst = 0;
    #2 check_reset_outputs("reset_async");
    tick();
    check_reset_outputs("reset_held");
    rst = 1;
    rr_ptr = 0;
    tick();
    checks++;
    if (core_rst !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: core_rst %b busy %b expected 0 0", core_rst, busy);
    end
  endtask

  task automatic test_basic();
    fixed_dly = 0;
    set_ops(0, 30, 7);
    req = 4'b0001;
    check_op(0, 1, 0, 1);
    fixed_dly = -1;
  endtask

  task automatic test_swap();
    set_ops(1, 15, 5);
    req = 4'b0010;
    check_op(1, 1, 0, 0);
    set_ops(1, 7, 30);
    req = 4'b0010;
    check_op(1, 1, 0, 0);
  endtask

  task automatic test_zero();
    set_ops(2, 0, 9);
    req = 4'b0100;
    check_op(2, 1, 0, 0);
  endtask

  task automatic test_round_robin();
    set_ops(0, 12, 18);
    set_ops(2, 21, 14);
    req = 4'b0101;
    for (int k = 0; k < 3; k++) check_op(pick(rr_ptr, req), 0, 0, 0);
    req = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 4; i++)
        set_ops(i, $urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 255)), int'($urandom_range(1, 255)));
      req = req | 4'($urandom_range(0, 15));
      if (req == 4'b0) req = 4'b1 << $urandom_range(0, 3);
      check_op(pick(rr_ptr, req), 1'($urandom_range(0, 1)), 0, 0);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    never_ready = 1;
    set_ops(3, 40, 24);
    req = 4'b1000;
    check_op(3, 1, 1, 0);
    never_ready = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    never_ready = 1;
    set_ops(3, 12, 18);
    req = 4'b1000;
    n = 0;
    while (grant == 4'b0 && n < 10) begin
      tick();
      n++;
    end
    req = 4'b0000;
    tick();
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || core_a_available !== 1'b1 || core_b_available !== 1'b0) begin
      errors++;
      $display("FAIL in_wait: busy %b av %b%b expected 1 10", busy, core_a_available, core_b_available);
    end
    #2 rst = 0;
    #1 check_reset_outputs("reset_mid");
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (done !== 4'b0) begin
        errors++;
        $display("FAIL reset_no_done: got %b expected 0000", done);
      end
    end
    never_ready = 0;
    rst = 1;
    rr_ptr = 0;
    set_ops(2, 48, 36);
    req = 4'b0100;
    check_op(2, 1, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_swap();
    test_zero();
    test_round_robin();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
